// File: rtl/ship_life_pkg.sv
// Shared types and widths for the player ship life/sequencing controller.
// Imported by the controller, its interface and the bench.
package ship_life_pkg;

  localparam int FRAME_CNT_W = 8;
  localparam int LIVES_W     = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ALIVE     = 3'd1,
    DYING     = 3'd2,
    RESPAWN   = 3'd3,
    GAME_OVER = 3'd4
  } ship_state_t;

endpackage

// File: rtl/ship_life_ctl_if.sv
// Control bundle between the ship life controller and the drawing chain.
// master = controller side, slave = sprite/position/HUD side.
interface ship_life_ctl_if;
  import ship_life_pkg::*;

  logic               start_button;
  logic               ship_hit;
  logic               ship_active;
  logic               ship_visible;
  logic               ship_dead;
  logic               ship_reset;
  logic [LIVES_W-1:0] lives;
  logic               game_over;

  modport master (
    input  start_button,
    input  ship_hit,
    output ship_active,
    output ship_visible,
    output ship_dead,
    output ship_reset,
    output lives,
    output game_over
  );

  modport slave (
    output start_button,
    output ship_hit,
    input  ship_active,
    input  ship_visible,
    input  ship_dead,
    input  ship_reset,
    input  lives,
    input  game_over
  );

endinterface

// File: rtl/frame_tick_gen.sv
// One-pclk frame tick from the rising edge of a registered vsync.
// Reusable by any frame-timed controller.
module frame_tick_gen (
  input  logic pclk,
  input  logic rst,
  input  logic vsync_in,
  output logic frame_tick
);

  logic vs_q;
  logic vs_p;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_q <= 1'b0;
      vs_p <= 1'b0;
    end else begin
      vs_q <= vsync_in;
      vs_p <= vs_q;
    end
  end

  assign frame_tick = vs_q & ~vs_p;

endmodule

// File: rtl/ship_life_ctl.sv
// Player ship sequencer: start, alive, dying, blinking respawn, game over.
// Outputs are registered from the state one pclk after it updates.
module ship_life_ctl #(
  parameter int LIVES         = 3,
  parameter int DEATH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            vsync_in,
  ship_life_ctl_if.master ctl
);
  import ship_life_pkg::*;

  localparam logic [LIVES_W-1:0] LIVES_INIT =
    LIVES_W'(LIVES);
  localparam logic [FRAME_CNT_W-1:0] DEATH_N =
    FRAME_CNT_W'(DEATH_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] INVULN_N =
    FRAME_CNT_W'(INVULN_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] BLINK_N =
    FRAME_CNT_W'(BLINK_FRAMES);

  ship_state_t            state;
  logic [FRAME_CNT_W-1:0] cnt;
  logic [FRAME_CNT_W-1:0] cnt_inc;
  logic [LIVES_W-1:0]     lives_q;
  logic                   blink;
  logic                   start_q;
  logic                   reset_pend;
  logic                   frame_tick;
  logic                   start_rise;
  logic                   blink_flip;

  frame_tick_gen u_tick (
    .pclk       (pclk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .frame_tick (frame_tick)
  );

  assign cnt_inc    = cnt + FRAME_CNT_W'(1);
  assign start_rise = ctl.start_button & ~start_q;
  // Skip the flip that would land on the exit frame so the
  // ship never blanks for a single cycle on its way to ALIVE.
  assign blink_flip = frame_tick
                    && ((cnt_inc % BLINK_N) == '0)
                    && (cnt_inc != INVULN_N);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      lives_q          <= LIVES_INIT;
      blink            <= 1'b1;
      start_q          <= 1'b0;
      reset_pend       <= 1'b0;
      ctl.ship_active  <= 1'b0;
      ctl.ship_visible <= 1'b1;
      ctl.ship_dead    <= 1'b0;
      ctl.ship_reset   <= 1'b0;
      ctl.lives        <= LIVES_INIT;
      ctl.game_over    <= 1'b0;
    end else begin
      start_q    <= ctl.start_button;
      reset_pend <= 1'b0;
      if (frame_tick) cnt <= cnt_inc;

      ctl.ship_active  <= (state == ALIVE)
                       || (state == RESPAWN);
      ctl.ship_visible <= (state == RESPAWN) ? blink
                       : (state != GAME_OVER);
      ctl.ship_dead    <= (state == DYING);
      ctl.game_over    <= (state == GAME_OVER);
      ctl.ship_reset   <= reset_pend;
      ctl.lives        <= lives_q;

      // Every transition clears cnt, dropping a same-cycle tick.
      unique case (state)
        IDLE: begin
          if (ctl.start_button) begin
            state      <= ALIVE;
            lives_q    <= LIVES_INIT;
            reset_pend <= 1'b1;
            cnt        <= '0;
          end
        end
        ALIVE: begin
          if (ctl.ship_hit) begin
            state   <= DYING;
            lives_q <= lives_q - LIVES_W'(1);
            cnt     <= '0;
          end
        end
        DYING: begin
          if (cnt == DEATH_N) begin
            cnt <= '0;
            if (lives_q == '0) begin
              state <= GAME_OVER;
            end else begin
              state      <= RESPAWN;
              reset_pend <= 1'b1;
              blink      <= 1'b1;
            end
          end
        end
        RESPAWN: begin
          if (cnt == INVULN_N) begin
            state <= ALIVE;
            blink <= 1'b1;
            cnt   <= '0;
          end else if (blink_flip) begin
            blink <= ~blink;
          end
        end
        GAME_OVER: begin
          if (start_rise) begin
            state      <= ALIVE;
            lives_q    <= LIVES_INIT;
            reset_pend <= 1'b1;
            cnt        <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
